// File: rtl/masked_bv2_mul_pipe.sv
// rtl/masked_bv2_mul_pipe.sv - DOM-indep masked GF(2^2) normal-basis multiplier, valid/ready pipelined
// Optional output register stage: define MASKED_BV2_MUL_OUTPUT_REG_EN (latency 2 instead of 1).

module masked_bv2_nand_gate (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = ~(a & b);
endmodule

module masked_bv2_xor_gate (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a ^ b;
endmodule

// The inverters of the ANDs cancel pairwise: c0 = ~(a0&b0) ^ ~t = (a0&b0) ^ t.
module masked_bv2_gf_mul (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [1:0] c
);
    logic xa, xb, nt, n0, n1;

    (* keep = "true", dont_touch = "true" *)
    masked_bv2_xor_gate  u_xa (.a(a[0]), .b(a[1]), .y(xa));
    (* keep = "true", dont_touch = "true" *)
    masked_bv2_xor_gate  u_xb (.a(b[0]), .b(b[1]), .y(xb));
    (* keep = "true", dont_touch = "true" *)
    masked_bv2_nand_gate u_nt (.a(xa),   .b(xb),   .y(nt));
    (* keep = "true", dont_touch = "true" *)
    masked_bv2_nand_gate u_n0 (.a(a[0]), .b(b[0]), .y(n0));
    (* keep = "true", dont_touch = "true" *)
    masked_bv2_nand_gate u_n1 (.a(a[1]), .b(b[1]), .y(n1));
    (* keep = "true", dont_touch = "true" *)
    masked_bv2_xor_gate  u_c0 (.a(n0),   .b(nt),   .y(c[0]));
    (* keep = "true", dont_touch = "true" *)
    masked_bv2_xor_gate  u_c1 (.a(n1),   .b(nt),   .y(c[1]));
endmodule

module masked_bv2_mul_pipe #(
    parameter int NUM_SHARES = 2,
    parameter int NUM_LANES  = 1
) (
    input  logic                                                in_clock,
    input  logic                                                in_reset_n,
    input  logic [NUM_SHARES*NUM_LANES*2-1:0]                   in_a,
    input  logic [NUM_SHARES*NUM_LANES*2-1:0]                   in_b,
    input  logic [NUM_SHARES*(NUM_SHARES-1)/2*NUM_LANES*2-1:0]  in_r,
    input  logic                                                in_valid,
    output logic                                                in_ready,
    output logic [NUM_SHARES*NUM_LANES*2-1:0]                   out_c,
    output logic                                                out_valid,
    input  logic                                                out_ready
);
    localparam int NUM_PAIRS = NUM_SHARES*(NUM_SHARES-1)/2;
    localparam int W         = NUM_SHARES*NUM_LANES*2;

    logic [NUM_SHARES-1:0][NUM_SHARES-1:0][NUM_LANES-1:0][1:0] prod_d;
    logic [NUM_SHARES-1:0][NUM_SHARES-1:0][NUM_LANES-1:0][1:0] p_q;
    logic [W-1:0] comp;
    logic         s1_full;
    logic         s1_release;
    logic         accept;

    for (genvar gi = 0; gi < NUM_SHARES; gi++) begin : g_i
        for (genvar gj = 0; gj < NUM_SHARES; gj++) begin : g_j
            for (genvar gl = 0; gl < NUM_LANES; gl++) begin : g_l
                logic [1:0] mul_c;
                masked_bv2_gf_mul u_mul (
                    .a(in_a[(gi*NUM_LANES+gl)*2 +: 2]),
                    .b(in_b[(gj*NUM_LANES+gl)*2 +: 2]),
                    .c(mul_c)
                );
                if (gi == gj) begin : g_diag
                    assign prod_d[gi][gj][gl] = mul_c;
                end else begin : g_cross
                    // (i,j) and (j,i) are refreshed with the same pair mask so it cancels on recombination
                    localparam int LO   = (gi < gj) ? gi : gj;
                    localparam int HI   = (gi < gj) ? gj : gi;
                    localparam int PIDX = LO*NUM_SHARES - LO*(LO+1)/2 + (HI-LO-1);
                    for (genvar gb = 0; gb < 2; gb++) begin : g_bit
                        (* keep = "true", dont_touch = "true" *)
                        masked_bv2_xor_gate u_rx (
                            .a(mul_c[gb]),
                            .b(in_r[(PIDX*NUM_LANES+gl)*2+gb]),
                            .y(prod_d[gi][gj][gl][gb])
                        );
                    end
                end
            end
        end
    end

    assign accept = in_valid && in_ready;

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            p_q <= '0;
        end else if (accept) begin
            p_q <= prod_d;
        end
    end

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            s1_full <= 1'b0;
        end else if (accept) begin
            s1_full <= 1'b1;
        end else if (s1_release) begin
            s1_full <= 1'b0;
        end
    end

    // Cross-domain compression happens only after the partial products are registered
    always_comb begin
        comp = '0;
        for (int i = 0; i < NUM_SHARES; i++) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                for (int j = 0; j < NUM_SHARES; j++) begin
                    comp[(i*NUM_LANES+l)*2 +: 2] = comp[(i*NUM_LANES+l)*2 +: 2] ^ p_q[i][j][l];
                end
            end
        end
    end

`ifdef MASKED_BV2_MUL_OUTPUT_REG_EN
    logic [W-1:0] o_q;
    logic         o_full;

    assign s1_release = !o_full || out_ready;
    assign in_ready   = !s1_full || s1_release;

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            o_q    <= '0;
            o_full <= 1'b0;
        end else if (s1_release) begin
            o_full <= s1_full;
            if (s1_full) begin
                o_q <= comp;
            end
        end
    end

    assign out_c     = o_q;
    assign out_valid = o_full;
`else
    assign out_valid  = s1_full;
    assign out_c      = comp;
    assign s1_release = out_valid && out_ready;
    assign in_ready   = !s1_full || (out_ready && out_valid);
`endif

endmodule
